// File: rtl/b07_pkg.sv
// Shared types and constants for the b07 point generator and its LFSR.
// The LFSR step function lives here so the generator and the LFSR agree on it.
package b07_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_X = 2'd1,
    WR_Y = 2'd2,
    FIN  = 2'd3
  } b07_state_e;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] B07_LINE_C    = 8'h02;
  localparam int         B07_NUM_PAIRS = 8;
  localparam int         B07_MEM_DEPTH = 16;

  // Galois right-shift step; a nonzero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/b07_point_gen_if.sv
// Byte write port into the b07 point memory.
// The generator drives it through the master modport and the memory samples it through the slave modport.
interface b07_point_gen_if #(
  parameter int ADDR_W = $clog2(b07_pkg::B07_MEM_DEPTH)
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              on_line;

  modport master (output wr_en, output wr_addr, output wr_data, output on_line);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  on_line);

endinterface

// File: rtl/b07_lfsr8.sv
// 8-bit Galois LFSR with a synchronous load that takes priority over stepping.
// It resets to 8'h01 so the register never starts in the all-zero lock-up state.
module b07_lfsr8
  import b07_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= 8'h01;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/b07_point_gen.sv
// Writes an image of NUM_PAIRS (x, y) byte pairs. Exactly `target` of the pairs lie on 3x + y = LINE_C (mod 256).
// Every output is registered; state_q names the write currently shown on the bus.
module b07_point_gen
  import b07_pkg::*;
#(
  parameter int         NUM_PAIRS = B07_NUM_PAIRS,
  parameter logic [7:0] LINE_C    = B07_LINE_C
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             target,
  input  logic [7:0]             seed,
  b07_point_gen_if.master        wr,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int                PAIR_W     = $clog2(NUM_PAIRS);
  localparam int                ADDR_W     = PAIR_W + 1;
  localparam logic [3:0]        TARGET_MAX = 4'(NUM_PAIRS);
  localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(NUM_PAIRS - 1);

  b07_state_e        state_q, state_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [PAIR_W-1:0] phase_q, phase_d;
  logic [3:0]        target_q, target_d;
  logic [7:0]        x_q, x_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              on_line_q, on_line_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [7:0]        lfsr_seed;
  logic [7:0]        lfsr_q;
  logic [7:0]        seed_eff;
  logic [PAIR_W-1:0] pair_rel;
  logic [PAIR_W-1:0] pair_inc;
  logic              pair_on;
  logic [7:0]        y_on;
  logic [7:0]        y_off;

  // The x byte is written straight from seed_eff, so the LFSR is loaded one step ahead.
  // While a write is on the bus, lfsr_q already holds the value that the following byte needs.
  assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
  assign lfsr_seed = lfsr_next(seed_eff);

  b07_lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (lfsr_seed),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  // The on-line window starts at pair phase_q and wraps modulo NUM_PAIRS.
  assign pair_rel = pair_q - phase_q;
  assign pair_on  = (4'(pair_rel) < target_q);
  assign pair_inc = pair_q + PAIR_W'(1);
  assign y_on     = LINE_C - (x_q + {x_q[6:0], 1'b0});
  assign y_off    = y_on + (lfsr_q | 8'h01);

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    phase_d   = phase_q;
    target_d  = target_q;
    x_d       = x_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = 8'h00;
    on_line_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (target > TARGET_MAX) begin
            err_d = 1'b1;
          end else begin
            // The phase comes from the substituted seed, so seeds 00 and 01 produce the same image.
            target_d  = target;
            phase_d   = seed_eff[PAIR_W-1:0];
            lfsr_load = 1'b1;
            pair_d    = '0;
            x_d       = seed_eff;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = seed_eff;
            state_d   = WR_X;
          end
        end
      end
      WR_X: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {pair_q, 1'b1};
        wr_data_d = pair_on ? y_on : y_off;
        on_line_d = pair_on;
        lfsr_step = 1'b1;
        state_d   = WR_Y;
      end
      WR_Y: begin
        if (pair_q == LAST_PAIR) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          pair_d    = pair_inc;
          x_d       = lfsr_q;
          wr_en_d   = 1'b1;
          wr_addr_d = {pair_inc, 1'b0};
          wr_data_d = lfsr_q;
          lfsr_step = 1'b1;
          state_d   = WR_X;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      phase_q   <= '0;
      target_q  <= 4'h0;
      x_q       <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      on_line_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      phase_q   <= phase_d;
      target_q  <= target_d;
      x_q       <= x_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      on_line_q <= on_line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign wr.on_line = on_line_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
